// File: rtl/cordic_pkg.sv
// Shared types and constants for the iterative CORDIC engine.
// atan(2^-i) table is Q2.30; consumers narrow it to their own width.
package cordic_pkg;

  typedef enum logic {
    ROTATE = 1'b0,
    VECTOR = 1'b1
  } cordic_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    HOLD
  } engine_state_e;

  localparam logic signed [31:0] CORDIC_GAIN_Q2_30 = 32'sd1768195395;

  localparam logic signed [31:0] ATAN_Q2_30 [0:31] = '{
    32'sd843314857, 32'sd497837829, 32'sd263043837, 32'sd133525159,
    32'sd67021687,  32'sd33543516,  32'sd16775851,  32'sd8388437,
    32'sd4194283,   32'sd2097149,   32'sd1048576,   32'sd524288,
    32'sd262144,    32'sd131072,    32'sd65536,     32'sd32768,
    32'sd16384,     32'sd8192,      32'sd4096,      32'sd2048,
    32'sd1024,      32'sd512,       32'sd256,       32'sd128,
    32'sd64,        32'sd32,        32'sd16,        32'sd8,
    32'sd4,         32'sd2,         32'sd1,         32'sd1
  };

endpackage

// File: rtl/cordic_microrotation.sv
// One combinational CORDIC micro-rotation shared by the x, y and z lanes.
// Direction follows z sign in ROTATE and y sign in VECTOR.
module cordic_microrotation
  import cordic_pkg::*;
#(
  parameter int BIT_WIDTH = 16
) (
  input  logic signed [BIT_WIDTH-1:0] x,
  input  logic signed [BIT_WIDTH-1:0] y,
  input  logic signed [BIT_WIDTH-1:0] z,
  input  logic        [4:0]           shift,
  input  logic signed [BIT_WIDTH-1:0] atan,
  input  logic                        mode,
  output logic signed [BIT_WIDTH-1:0] x_next,
  output logic signed [BIT_WIDTH-1:0] y_next,
  output logic signed [BIT_WIDTH-1:0] z_next
);

  logic                        pos;
  logic signed [BIT_WIDTH-1:0] xs;
  logic signed [BIT_WIDTH-1:0] ys;

  assign pos = (mode == logic'(VECTOR)) ? y[BIT_WIDTH-1]
                                         : !z[BIT_WIDTH-1];
  assign xs = x >>> shift;
  assign ys = y >>> shift;

  always_comb begin
    if (pos) begin
      x_next = x - ys;
      y_next = y + xs;
      z_next = z - atan;
    end else begin
      x_next = x + ys;
      y_next = y - xs;
      z_next = z + atan;
    end
  end

endmodule

// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC engine: one micro-rotation per clock, valid/ready
// on both sides, result held in HOLD until the consumer takes it.
module cordic_iter_engine
  import cordic_pkg::*;
#(
  parameter int BIT_WIDTH  = 16,
  parameter int ITERATIONS = 14
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        in_valid_in,
  output logic                        in_ready_output,
  input  logic                        mode_in,
  input  logic signed [BIT_WIDTH-1:0] x_in,
  input  logic signed [BIT_WIDTH-1:0] y_in,
  input  logic signed [BIT_WIDTH-1:0] z_in,
  output logic                        out_valid_output,
  input  logic                        out_ready_in,
  output logic signed [BIT_WIDTH-1:0] x_output,
  output logic signed [BIT_WIDTH-1:0] y_output,
  output logic signed [BIT_WIDTH-1:0] z_output,
  output logic                        busy_output
);

  localparam logic [4:0] LAST = 5'(ITERATIONS - 1);

  engine_state_e               state;
  cordic_mode_e                mode_q;
  logic        [4:0]           cnt;
  logic signed [BIT_WIDTH-1:0] x_q, y_q, z_q;
  logic signed [BIT_WIDTH-1:0] x_nx, y_nx, z_nx;
  logic signed [BIT_WIDTH-1:0] atan_i;
  logic                        rdy_q, vld_q, busy_q;

  // Keep the top BIT_WIDTH bits of the Q2.30 entry (truncating).
  assign atan_i = BIT_WIDTH'(ATAN_Q2_30[cnt] >>> (32 - BIT_WIDTH));

  cordic_microrotation #(
    .BIT_WIDTH(BIT_WIDTH)
  ) u_rot (
    .x     (x_q),
    .y     (y_q),
    .z     (z_q),
    .shift (cnt),
    .atan  (atan_i),
    .mode  (logic'(mode_q)),
    .x_next(x_nx),
    .y_next(y_nx),
    .z_next(z_nx)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state  <= IDLE;
      mode_q <= ROTATE;
      cnt    <= '0;
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      rdy_q  <= 1'b1;
      vld_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid_in) begin
            mode_q <= cordic_mode_e'(mode_in);
            x_q    <= x_in;
            y_q    <= y_in;
            z_q    <= z_in;
            cnt    <= '0;
            state  <= ITER;
            rdy_q  <= 1'b0;
            busy_q <= 1'b1;
          end
        end
        ITER: begin
          x_q <= x_nx;
          y_q <= y_nx;
          z_q <= z_nx;
          cnt <= cnt + 5'd1;
          if (cnt == LAST) begin
            state  <= HOLD;
            busy_q <= 1'b0;
            vld_q  <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready_in) begin
            state <= IDLE;
            vld_q <= 1'b0;
            rdy_q <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          rdy_q  <= 1'b1;
          vld_q  <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_output  = rdy_q;
  assign out_valid_output = vld_q;
  assign busy_output      = busy_q;
  assign x_output         = x_q;
  assign y_output         = y_q;
  assign z_output         = z_q;

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Randomized and directed bench for cordic_iter_engine against an
// integer CORDIC reference plus ideal trig tolerances.
module tb_cordic_iter_engine;

  localparam int W = 16;
  localparam int N = 14;

  logic                clk_in = 1'b0;
  logic                rst_in;
  logic                in_valid_in;
  logic                in_ready_output;
  logic                mode_in;
  logic signed [W-1:0] x_in, y_in, z_in;
  logic                out_valid_output;
  logic                out_ready_in;
  logic signed [W-1:0] x_output, y_output, z_output;
  logic                busy_output;

  cordic_iter_engine #(
    .BIT_WIDTH (W),
    .ITERATIONS(N)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .in_valid_in     (in_valid_in),
    .in_ready_output (in_ready_output),
    .mode_in         (mode_in),
    .x_in            (x_in),
    .y_in            (y_in),
    .z_in            (z_in),
    .out_valid_output(out_valid_output),
    .out_ready_in    (out_ready_in),
    .x_output        (x_output),
    .y_output        (y_output),
    .z_output        (z_output),
    .busy_output     (busy_output)
  );

  always #5 clk_in = ~clk_in;

  int n_chk  = 0;
  int n_fail = 0;
  int atab[N];

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit near(longint a, longint b, longint t);
    return (a - b <= t) && (b - a <= t);
  endfunction

  function automatic void model(
    input  bit                  m,
    input  logic signed [W-1:0] x0, y0, z0,
    output logic signed [W-1:0] xr, yr, zr
  );
    logic signed [W-1:0] x, y, z, sx, sy;
    bit pos;
    x = x0;
    y = y0;
    z = z0;
    for (int i = 0; i < N; i++) begin
      pos = m ? (y < 0) : (z >= 0);
      sx = x >>> i;
      sy = y >>> i;
      if (pos) begin
        x = x - sy;
        y = y + sx;
        z = z - W'(atab[i]);
      end else begin
        x = x + sy;
        y = y - sx;
        z = z + W'(atab[i]);
      end
    end
    xr = x;
    yr = y;
    zr = z;
  endfunction

  task automatic wait_ready();
    int g = 0;
    while (!in_ready_output && g < 50) begin
      @(posedge clk_in);
      #1;
      g++;
    end
    chk("ready_before", in_ready_output, 1);
  endtask

  task automatic op(
    input  bit                  m,
    input  logic signed [W-1:0] x, y, z,
    input  int                  hold,
    output logic signed [W-1:0] rx, ry, rz
  );
    int lat;
    bit stable;
    logic signed [W-1:0] ex, ey, ez;
    wait_ready();
    mode_in     = m;
    x_in        = x;
    y_in        = y;
    z_in        = z;
    in_valid_in = 1'b1;
    @(posedge clk_in);
    #1;
    in_valid_in = 1'b0;
    chk("busy", busy_output, 1);
    mode_in = ~m;
    x_in    = W'($urandom);
    y_in    = W'($urandom);
    z_in    = W'($urandom);
    lat = 0;
    while (!out_valid_output && lat < 100) begin
      @(posedge clk_in);
      #1;
      lat++;
    end
    chk("latency", lat, N);
    rx = x_output;
    ry = y_output;
    rz = z_output;
    stable = 1'b1;
    for (int c = 0; c < hold; c++) begin
      in_valid_in = 1'($urandom);
      x_in = W'($urandom);
      z_in = W'($urandom);
      @(posedge clk_in);
      #1;
      if (x_output !== rx || y_output !== ry || z_output !== rz ||
          !out_valid_output || in_ready_output || busy_output)
        stable = 1'b0;
    end
    in_valid_in = 1'b0;
    if (hold > 0) chk("hold_stable", stable, 1);
    out_ready_in = 1'b1;
    @(posedge clk_in);
    #1;
    out_ready_in = 1'b0;
    chk("ready_after", in_ready_output, 1);
    chk("valid_drop", out_valid_output, 0);
    model(m, x, y, z, ex, ey, ez);
    chk("model_x", rx, ex);
    chk("model_y", ry, ey);
    chk("model_z", rz, ez);
  endtask

  logic signed [W-1:0] rx, ry, rz;
  logic signed [W-1:0] px, py, pz;
  bit                  pm;

  initial begin
    for (int i = 0; i < N; i++) begin
      real r;
      longint q;
      r = $atan(2.0 ** (-i)) * 1073741824.0;
      q = longint'($rtoi(r + 0.5));
      atab[i] = int'(q >>> (32 - W));
    end

    rst_in       = 1'b1;
    in_valid_in  = 1'b0;
    out_ready_in = 1'b0;
    mode_in      = 1'b0;
    x_in         = '0;
    y_in         = '0;
    z_in         = '0;
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    chk("rst_ready", in_ready_output, 1);
    chk("rst_valid", out_valid_output, 0);
    chk("rst_busy", busy_output, 0);
    chk("rst_x", x_output, 0);
    chk("rst_z", z_output, 0);

    op(0, 16'sd9949, 16'sd0, 16'sd0, 0, rx, ry, rz);
    chk("rot0_x", near(rx, 16384, 4), 1);
    chk("rot0_y", near(ry, 0, 4), 1);
    chk("rot0_z", near(rz, 0, 4), 1);

    op(0, 16'sd9949, 16'sd0, 16'sd12868, 0, rx, ry, rz);
    chk("rot45_x", near(rx, 11585, 4), 1);
    chk("rot45_y", near(ry, 11585, 4), 1);
    chk("rot45_z", near(rz, 0, 4), 1);

    op(1, 16'sd8192, 16'sd8192, 16'sd0, 0, rx, ry, rz);
    chk("vec_z", near(rz, 12868, 4), 1);
    chk("vec_y", near(ry, 0, 4), 1);
    chk("vec_x", near(rx, 19078, 6), 1);

    op(0, 16'sd9949, 16'sd0, -16'sd12868, 20, rx, ry, rz);
    chk("neg_x", near(rx, 11585, 4), 1);
    chk("neg_y", near(ry, -11585, 4), 1);

    wait_ready();
    mode_in     = 1'b0;
    x_in        = 16'sd9949;
    y_in        = 16'sd0;
    z_in        = 16'sd5000;
    in_valid_in = 1'b1;
    @(posedge clk_in);
    #1;
    in_valid_in = 1'b0;
    repeat (5) @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    chk("mid_rst_ready", in_ready_output, 1);
    chk("mid_rst_valid", out_valid_output, 0);
    chk("mid_rst_busy", busy_output, 0);
    chk("mid_rst_x", x_output, 0);
    chk("mid_rst_y", y_output, 0);
    chk("mid_rst_z", z_output, 0);
    repeat (N + 2) @(posedge clk_in);
    #1;
    chk("mid_rst_no_out", out_valid_output, 0);
    op(0, 16'sd9949, 16'sd0, 16'sd0, 0, rx, ry, rz);
    chk("post_rst_x", near(rx, 16384, 4), 1);

    for (int k = 0; k < 30; k++) begin
      pm = 1'($urandom);
      if (pm) begin
        px = W'($urandom_range(16000, 1));
        py = W'(int'($urandom_range(32000, 0)) - 16000);
        pz = W'(int'($urandom_range(20000, 0)) - 10000);
      end else begin
        px = W'(int'($urandom_range(20000, 0)) - 10000);
        py = W'(int'($urandom_range(20000, 0)) - 10000);
        pz = W'(int'($urandom_range(57000, 0)) - 28500);
      end
      op(pm, px, py, pz, int'($urandom_range(3, 0)), rx, ry, rz);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cordic_iter_engine.md
Name: cordic_iter_engine

Overview:
- Iterative, parametrised CORDIC engine: one micro-rotation per clock, reusing a single add/sub datapath for the x, y and z lanes.
- Supports rotation mode (drive z to 0; yields scaled cos/sin) and vectoring mode (drive y to 0; yields scaled magnitude and atan).
- Sits between the angle/vector source and downstream consumers, with valid/ready handshakes on both sides.
- Gain (~1.6468) is not compensated internally; callers pre-scale inputs.

Parameters:
- BIT_WIDTH, 16, width of x/y/z; all signed Q2.(BIT_WIDTH-2); legal range 8..32.
- ITERATIONS, 14, micro-rotations per operation; legal range 1..min(BIT_WIDTH-1, 32).

Ports:
- clk_in  input  1  clock; all logic on rising edge.
- rst_in  input  1  synchronous, active-high reset.
- in_valid_in  input  1  operands/mode valid.
- in_ready_output  output  1  engine can accept operands.
- mode_in  input  1  0 = ROTATE, 1 = VECTOR.
- x_in  input  BIT_WIDTH  signed initial x.
- y_in  input  BIT_WIDTH  signed initial y.
- z_in  input  BIT_WIDTH  signed initial angle (radians).
- out_valid_output  output  1  result valid.
- out_ready_in  input  1  consumer accepts result.
- x_output  output  BIT_WIDTH  signed final x.
- y_output  output  BIT_WIDTH  signed final y.
- z_output  output  BIT_WIDTH  signed final z.
- busy_output  output  1  high in ITER state.

Behaviour:
- Reset (rst_in=1 at an edge): state IDLE, iteration counter 0, x/y/z registers 0, out_valid_output=0, busy_output=0, in_ready_output=1. Reset wins over any simultaneous handshake. Reset mid-ITER or mid-HOLD discards the operation with no output.
- FSM states: IDLE, ITER, HOLD.
- IDLE:
  - in_ready_output=1.
  - On in_valid_in=1: latch x_in, y_in, z_in and mode_in; counter i=0; go to ITER.
- ITER:
  - in_ready_output=0, busy_output=1.
  - Each cycle apply micro-rotation i, then i++.
  - After the cycle with i=ITERATIONS-1, go to HOLD.
- HOLD:
  - out_valid_output=1; outputs stable.
  - On out_ready_in=1, go to IDLE.
  - out_valid_output is held indefinitely while out_ready_in=0.
  - Input accepted on the cycle after the HOLD→IDLE transition, never on the same cycle.
- Latency: input accepted at edge k; out_valid_output high after edge k+ITERATIONS. Minimum initiation interval is ITERATIONS+2 cycles.
- Direction d ∈ {+1,-1}:
  - ROTATE: d=+1 if z≥0, else −1.
  - VECTOR: d=+1 if y<0, else −1.
- Update, using pre-update values on all right-hand sides:
  - x' = x − d·(y>>>i)
  - y' = y + d·(x>>>i)
  - z' = z − d·atan_i
- Arithmetic:
  - >>> is arithmetic shift.
  - Add/sub is BIT_WIDTH two's complement and wraps on overflow; no saturation, no flag.
- atan_i = upper BIT_WIDTH bits of the package table entry ATAN_Q2_30[i] (arithmetic shift right by 32−BIT_WIDTH, truncating).
- Convergence domain:
  - ROTATE: |z_in| ≤ 1.74 rad.
  - VECTOR: x_in > 0.
  - Outside this domain results are unspecified but deterministic; no error is signalled.
- Mode and operands are captured only at acceptance; changes on the inputs during ITER/HOLD are ignored.

Decomposition:
- cordic_pkg holds:
  - ATAN_Q2_30[0:31]: signed 32-bit atan(2^-i), Q2.30.
  - typedef enum cordic_mode_e {ROTATE, VECTOR}.
  - typedef enum engine_state_e {IDLE, ITER, HOLD}.
  - Constant CORDIC_GAIN_Q2_30.
- Sub-module cordic_microrotation (combinational):
  - Inputs: x, y, z, shift i, atan_i, mode.
  - Outputs: x', y', z'.
  - Instantiated once; the engine holds registers, counter and FSM.

Test Plan:
- ROTATE, z=0: BIT_WIDTH=16, ITERATIONS=14, x_in=9949 (0.60725), y_in=0, z_in=0 → x_output=16384±4, y_output=0±4, |z_output|≤4; out_valid_output rises 14 edges after acceptance.
- ROTATE, z=π/4: x_in=9949, y_in=0, z_in=12868 → x_output=11585±4, y_output=11585±4, |z_output|≤4.
- VECTOR: mode=1, x_in=8192, y_in=8192, z_in=0 → z_output=12868±4, |y_output|≤4, x_output=19078±6.
- Backpressure: hold out_ready_in=0 for 20 cycles after out_valid_output → outputs and out_valid_output stable, in_ready_output=0, in_valid_in pulses ignored; release → one transfer, in_ready_output=1 next cycle.
- Reset mid-operation: assert rst_in at iteration 5 for one cycle → next cycle IDLE, all outputs 0, in_ready_output=1; a new operation then completes correctly.
- Negative angle / mode capture: z_in=−12868, toggle mode_in during ITER → y_output=−11585±4, x_output=11585±4 (ROTATE result, unaffected by the toggle).
